// File: rtl/prbs_pkg.sv
// Shared definitions for the burst PRBS controller: FSM state encoding and
// feedback tap pairs for the supported PRBS orders.
package prbs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } state_t;

   localparam int PRBS7_TAP_A  = 7;
   localparam int PRBS7_TAP_B  = 6;
   localparam int PRBS15_TAP_A = 15;
   localparam int PRBS15_TAP_B = 14;
   localparam int PRBS31_TAP_A = 31;
   localparam int PRBS31_TAP_B = 28;

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR datapath: shifts left, feedback from two 1-based taps into bit 0.
// Load has priority over shift; the register resets to 1 so it never starts locked.
module prbs_lfsr
   import prbs_pkg::*;
#(
   parameter int LFSR_W = PRBS31_TAP_A,
   parameter int TAP_A  = PRBS31_TAP_A,
   parameter int TAP_B  = PRBS31_TAP_B
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              shift,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (shift) begin
         q_d = {q_q[LFSR_W-2:0], q_q[TAP_A-1] ^ q_q[TAP_B-1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= {{(LFSR_W-1){1'b0}}, 1'b1};
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer around prbs_lfsr: seed load, N-bit run with pause, abort and
// completion pulses. The burst counter is a down-counter with terminal count at 1.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; lfsr holds its value between bursts
//   ST_LOAD  | one cycle after seed capture, no bit emitted
//   ST_RUN   | one bit per cycle unless paused; counter decrements per bit
//   ST_DONE  | done pulse, burst completed normally
//   ST_ABORT | aborted pulse, burst terminated early
module prbs_burst_ctrl
   import prbs_pkg::*;
#(
   parameter int LFSR_W = PRBS31_TAP_A,
   parameter int TAP_A  = PRBS31_TAP_A,
   parameter int TAP_B  = PRBS31_TAP_B,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              pause,
   input  logic [LFSR_W-1:0] seed,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              prbs_bit,
   output logic              bit_valid,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              seed_fixed,
   output logic [LEN_W-1:0]  bits_left
);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic              seed_fixed_q, seed_fixed_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic              busy_q, busy_d;
   logic              lfsr_load, lfsr_shift;
   logic [LFSR_W-1:0] lfsr_load_val, lfsr_q;
   logic              run_bit;

   assign run_bit = (state_q == ST_RUN) && !pause;

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      seed_fixed_d  = seed_fixed_q;
      lfsr_load     = 1'b0;
      lfsr_shift    = 1'b0;
      lfsr_load_val = (seed == '0) ? LFSR_W'(1) : seed;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               count_d      = burst_len;
               seed_fixed_d = 1'b0;
               if (burst_len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d      = ST_LOAD;
                  lfsr_load    = 1'b1;
                  seed_fixed_d = (seed == '0);
               end
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            if (run_bit) begin
               lfsr_shift = 1'b1;
               if (count_q != '0) count_d = count_q - LEN_W'(1);
               if (count_q == LEN_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_ABORT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Abort overrides completion and pause; the bit emitted this cycle still counts.
      if (abort && (state_q inside {ST_LOAD, ST_RUN, ST_DONE})) state_d = ST_ABORT;

      // Recovery guard: an all-zero register would lock the generator forever.
      if (state_q != ST_IDLE && lfsr_q == '0) begin
         lfsr_load     = 1'b1;
         lfsr_load_val = LFSR_W'(1);
      end

      done_d    = (state_d == ST_DONE);
      aborted_d = (state_d == ST_ABORT);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         seed_fixed_q <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         seed_fixed_q <= seed_fixed_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         busy_q       <= busy_d;
      end
   end

   prbs_lfsr #(
      .LFSR_W (LFSR_W),
      .TAP_A  (TAP_A),
      .TAP_B  (TAP_B)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .shift    (lfsr_shift),
      .q        (lfsr_q)
   );

   assign prbs_bit   = lfsr_q[LFSR_W-1];
   assign bit_valid  = run_bit;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign seed_fixed = seed_fixed_q;
   assign bits_left  = count_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl at PRBS7: directed bursts plus random start/abort/pause
// traffic, all checked every cycle against a bit-sequence reference model.
module tb_prbs_burst_ctrl;
   import prbs_pkg::*;

   localparam int W  = 7;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, pause = 1'b0;
   logic [W-1:0]  seed = '0;
   logic [LW-1:0] burst_len = '0;
   logic          prbs_bit, bit_valid, busy, done, aborted, seed_fixed;
   logic [LW-1:0] bits_left;

   prbs_burst_ctrl #(
      .LFSR_W (W),
      .TAP_A  (PRBS7_TAP_A),
      .TAP_B  (PRBS7_TAP_B),
      .LEN_W  (LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .pause      (pause),
      .seed       (seed),
      .burst_len  (burst_len),
      .prbs_bit   (prbs_bit),
      .bit_valid  (bit_valid),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .seed_fixed (seed_fixed),
      .bits_left  (bits_left)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: win holds the next W sequence bits, win[0] is the bit on the pin.
   // The sequence obeys s[n+W] = s[n] ^ s[n+1] (taps 7,6 seen from the oldest bit).
   bit win[$];
   int m_left;
   bit m_load, m_run, m_done, m_abt, m_fix;

   int cyc = 0;
   bit obs_bits[$];
   int done_cnt = 0, abt_cnt = 0, last_done_cyc = -1;

   function automatic void m_seed(input logic [W-1:0] sd);
      win.delete();
      for (int j = 0; j < W; j++) win.push_back(sd[W-1-j]);
   endfunction

   function automatic void m_reset();
      m_seed(W'(1));
      m_left = 0;
      m_load = 0; m_run = 0; m_done = 0; m_abt = 0; m_fix = 0;
   endfunction

   task automatic step(input bit s, input bit a, input bit p,
                       input logic [W-1:0] sd, input logic [LW-1:0] ln);
      bit busy_e, valid_e;
      bit n_load, n_run, n_done, n_abt;
      @(negedge clk);
      start = s; abort = a; pause = p; seed = sd; burst_len = ln;
      #1;
      busy_e  = m_load | m_run | m_done | m_abt;
      valid_e = m_run & !p;
      check("prbs_bit",   32'(prbs_bit),   32'(win[0]));
      check("bit_valid",  32'(bit_valid),  32'(valid_e));
      check("busy",       32'(busy),       32'(busy_e));
      check("done",       32'(done),       32'(m_done));
      check("aborted",    32'(aborted),    32'(m_abt));
      check("seed_fixed", 32'(seed_fixed), 32'(m_fix));
      check("bits_left",  32'(bits_left),  32'(m_left));
      if (bit_valid) obs_bits.push_back(prbs_bit);
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (aborted) abt_cnt++;

      n_load = 0; n_run = 0; n_done = 0; n_abt = 0;
      if (!busy_e) begin
         if (s) begin
            m_left = int'(ln);
            m_fix  = 0;
            if (ln == 0) begin
               n_done = 1;
            end else begin
               n_load = 1;
               m_fix  = (sd == 0);
               m_seed((sd == 0) ? W'(1) : sd);
            end
         end
      end else begin
         if (valid_e) begin
            bit nb;
            nb = win[0] ^ win[1];
            void'(win.pop_front());
            win.push_back(nb);
            if (m_left >= 1) m_left--;
         end
         if (a && (m_load || m_run || m_done)) n_abt = 1;
         else if (m_load) n_run = 1;
         else if (m_run) begin
            if (valid_e && m_left == 0) n_done = 1;
            else n_run = 1;
         end
      end
      m_load = n_load; m_run = n_run; m_done = n_done; m_abt = n_abt;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
   endtask

   function automatic logic [31:0] pack_bits(input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n && i < obs_bits.size(); i++) v = {v[30:0], obs_bits[i]};
      return v;
   endfunction

   initial begin
      int cs, d0, a0, mism;
      logic [W-1:0] rs;
      logic [LW-1:0] rl;

      m_reset();
      #12;
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_valid",     32'(bit_valid), 32'd0);
      check("rst_bits_left", 32'(bits_left), 32'd0);
      check("rst_prbs_bit",  32'(prbs_bit),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // seed 1, 8 bits
      obs_bits.delete(); d0 = done_cnt; cs = cyc;
      step(1, 0, 0, 7'h01, 16'd8);
      idle(12);
      check("b8_count", 32'(obs_bits.size()), 32'd8);
      check("b8_bits",  pack_bits(8), 32'b00000010);
      check("b8_done",  32'(done_cnt - d0), 32'd1);
      check("b8_done_cyc", 32'(last_done_cyc), 32'(cs + 10));

      // full period: 254 bits repeat after 127
      obs_bits.delete();
      step(1, 0, 0, 7'h01, 16'd254);
      idle(260);
      check("p254_count", 32'(obs_bits.size()), 32'd254);
      mism = 0;
      for (int i = 0; i < 127 && i + 127 < obs_bits.size(); i++)
         if (obs_bits[i] != obs_bits[i+127]) mism++;
      check("p254_period", 32'(mism), 32'd0);
      check("p254_lfsr", 32'(dut.u_lfsr.q), 32'h01);
      step(1, 0, 0, 7'h01, 16'd127);
      idle(132);
      check("p127_lfsr", 32'(dut.u_lfsr.q), 32'h01);

      // zero seed replaced by 1
      obs_bits.delete(); d0 = done_cnt;
      step(1, 0, 0, 7'h00, 16'd4);
      idle(8);
      check("z_bits", pack_bits(4), 32'b0000);
      check("z_fixed", 32'(seed_fixed), 32'd1);
      check("z_done", 32'(done_cnt - d0), 32'd1);

      // pause for 3 cycles mid-burst
      obs_bits.delete(); d0 = done_cnt; cs = cyc;
      step(1, 0, 0, 7'h01, 16'd10);
      idle(5);
      for (int i = 0; i < 3; i++) step(0, 0, 1, '0, '0);
      idle(12);
      check("pz_count", 32'(obs_bits.size()), 32'd10);
      check("pz_bits",  pack_bits(10), 32'b0000001000);
      check("pz_done_cyc", 32'(last_done_cyc), 32'(cs + 15));

      // abort on the 5th valid bit; a start while busy is ignored
      obs_bits.delete(); d0 = done_cnt; a0 = abt_cnt;
      step(1, 0, 0, 7'h55, 16'd10);
      idle(2);
      step(1, 0, 0, 7'h00, 16'd3);
      idle(2);
      step(0, 1, 0, '0, '0);
      idle(4);
      check("ab_count", 32'(obs_bits.size()), 32'd5);
      check("ab_aborted", 32'(abt_cnt - a0), 32'd1);
      check("ab_no_done", 32'(done_cnt - d0), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);

      // asynchronous reset in RUN
      step(1, 0, 0, 7'h3c, 16'd20);
      idle(6);
      #2 rst_n = 1'b0;
      #1;
      check("ar_busy",      32'(busy),       32'd0);
      check("ar_valid",     32'(bit_valid),  32'd0);
      check("ar_done",      32'(done),       32'd0);
      check("ar_aborted",   32'(aborted),    32'd0);
      check("ar_bits_left", 32'(bits_left),  32'd0);
      check("ar_lfsr",      32'(dut.u_lfsr.q), 32'h01);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // zero-length burst
      obs_bits.delete(); d0 = done_cnt;
      step(1, 0, 0, 7'h22, 16'd0);
      idle(3);
      check("z0_bits", 32'(obs_bits.size()), 32'd0);
      check("z0_done", 32'(done_cnt - d0), 32'd1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rs = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
         rl = LW'($urandom_range(0, 24));
         step($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 3) == 0, rs, rl);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
